crossbar_switch_pipe: RTL

//  Registered NxN crossbar, successor of the combinational crossbar_switch, with

---
 rtl/crossbar_pkg.sv | 21 ++
 rtl/crossbar_map_checker.sv | 70 +++++++
 rtl/crossbar_switch_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// ----------------------------------------------------------------------------
// crossbar_pkg
// Shared types and helpers for the registered crossbar switch.
//   xbar_state_e : configuration FSM states (IDLE, CHECK, APPLY, REJECT)
//   rot_idx      : (o + s) mod n, the input port feeding output o at rotation s
// ----------------------------------------------------------------------------
package crossbar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        APPLY  = 2'd2,
        REJECT = 2'd3
    } xbar_state_e;

    // n is a power of two, so the modulo reduces to truncation in hardware.
    function automatic int rot_idx(input int o, input int s, input int n);
        return (o + s) % n;
    endfunction

endpackage

// File: rtl/crossbar_map_checker.sv
// ----------------------------------------------------------------------------
// crossbar_map_checker
// Combinational legality check of a shadow crossbar configuration. Only
// enabled outputs take part. A configuration is legal when every enabled
// output o selects input (o + s) mod N for one common rotation s.
// Ports:
//   i_sel       [N][clog2N] per-output selected input
//   i_en        [N]         per-output enable
//   o_legal                 configuration may be committed
//   o_collision             two enabled outputs select the same input
//   o_mapping               no single common rotation exists (set on collision too)
//   o_shift     [clog2N]    derived rotation (0 when nothing is enabled)
// ----------------------------------------------------------------------------
module crossbar_map_checker #(
    parameter int N = 8
) (
    input  logic [N-1:0][$clog2(N)-1:0] i_sel,
    input  logic [N-1:0]                i_en,
    output logic                        o_legal,
    output logic                        o_collision,
    output logic                        o_mapping,
    output logic [$clog2(N)-1:0]        o_shift
);

    localparam int IW = $clog2(N);

    logic          w_found;
    logic          w_mism;
    logic          w_coll;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_diff;

    // The first enabled output fixes the candidate rotation; every later
    // enabled output must reproduce it. Subtraction wraps mod N for free.
    always_comb begin
        w_found = 1'b0;
        w_mism  = 1'b0;
        w_cand  = '0;
        w_diff  = '0;
        for (int o = 0; o < N; o++) begin
            w_diff = i_sel[o] - IW'(o);
            if (i_en[o]) begin
                if (!w_found) begin
                    w_cand  = w_diff;
                    w_found = 1'b1;
                end else if (w_diff != w_cand) begin
                    w_mism = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_coll = 1'b0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                if (i_en[a] && i_en[b] && (i_sel[a] == i_sel[b])) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    // A collision can never satisfy a single rotation, so it also flags mapping.
    assign o_collision = w_coll;
    assign o_mapping   = w_mism | w_coll;
    assign o_legal     = ~(w_mism | w_coll);
    assign o_shift     = w_cand;

endmodule

// File: rtl/crossbar_switch_pipe.sv
// ----------------------------------------------------------------------------
// crossbar_switch_pipe
// Registered NxN rotation crossbar with a handshaked, atomically committed
// configuration. An offered mapping is captured into shadow registers, checked
// by crossbar_map_checker, and either committed to the active registers or
// rejected with sticky error flags. Datapath latency is one clock.
// Optional feature macro: CROSSBAR_STATS_EN (adds commit/reject counters).
// Ports:
//   clk, rst                       clock (rising), asynchronous active-high reset
//   in[N][W], in_valid             ingress data, shared valid
//   cfg_valid / cfg_ready          configuration handshake
//   cfg_input_sel[N], cfg_output_enable[N]  offered mapping
//   flush                          clear all active enables at the next edge
//   out[N][W], out_valid[N]        registered egress data and valids
//   active_shift                   committed rotation
//   cfg_done                       one-cycle pulse when a check finishes
//   mapping_error, collision_error sticky result of the last configuration
//   cfg_commit_cnt, cfg_reject_cnt saturating counters (CROSSBAR_STATS_EN only)
// ----------------------------------------------------------------------------
module crossbar_switch_pipe
    import crossbar_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0][W-1:0]         in,
    input  logic                        in_valid,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [N-1:0][$clog2(N)-1:0] cfg_input_sel,
    input  logic [N-1:0]                cfg_output_enable,
    input  logic                        flush,
    output logic [N-1:0][W-1:0]         out,
    output logic [N-1:0]                out_valid,
    output logic [$clog2(N)-1:0]        active_shift,
    output logic                        cfg_done,
    output logic                        mapping_error,
`ifdef CROSSBAR_STATS_EN
    output logic [15:0]                 cfg_commit_cnt,
    output logic [15:0]                 cfg_reject_cnt,
`endif
    output logic                        collision_error
);

    localparam int IW = $clog2(N);

    xbar_state_e r_state;
    xbar_state_e w_state_nxt;
    logic        w_cfg_ready;
    logic        w_accept;

    logic [N-1:0][IW-1:0] r_shadow_sel;
    logic [N-1:0]         r_shadow_en;

    logic          w_chk_legal;
    logic          w_chk_coll;
    logic          w_chk_map;
    logic [IW-1:0] w_chk_shift;

    logic          r_chk_coll;
    logic          r_chk_map;
    logic [IW-1:0] r_chk_shift;

    logic [N-1:0]  r_act_en;
    logic [IW-1:0] r_act_shift;
    logic          r_map_err;
    logic          r_coll_err;
    logic          r_cfg_done;

    logic [IW-1:0]         w_rot_idx [N];
    logic [N-1:0][W-1:0]   w_out_p0;
    logic [N-1:0]          w_vld_p0;
    logic [N-1:0][W-1:0]   r_out_p1;
    logic [N-1:0]          r_vld_p1;

    crossbar_map_checker #(
        .N (N)
    ) u_checker (
        .i_sel       (r_shadow_sel),
        .i_en        (r_shadow_en),
        .o_legal     (w_chk_legal),
        .o_collision (w_chk_coll),
        .o_mapping   (w_chk_map),
        .o_shift     (w_chk_shift)
    );

    // ---------------- configuration FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK:   w_state_nxt = w_chk_legal ? APPLY : REJECT;
            APPLY:   w_state_nxt = IDLE;
            REJECT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- shadow / check / active registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_sel <= '0;
            r_shadow_en  <= '0;
            r_chk_coll   <= 1'b0;
            r_chk_map    <= 1'b0;
            r_chk_shift  <= '0;
            r_act_en     <= '0;
            r_act_shift  <= '0;
            r_map_err    <= 1'b0;
            r_coll_err   <= 1'b0;
            r_cfg_done   <= 1'b0;
        end else begin
            r_cfg_done <= (r_state == APPLY) || (r_state == REJECT);

            if (w_accept) begin
                r_shadow_sel <= cfg_input_sel;
                r_shadow_en  <= cfg_output_enable;
                r_map_err    <= 1'b0;
                r_coll_err   <= 1'b0;
            end

            if (r_state == CHECK) begin
                r_chk_coll  <= w_chk_coll;
                r_chk_map   <= w_chk_map;
                r_chk_shift <= w_chk_shift;
            end

            if (r_state == REJECT) begin
                r_map_err  <= r_chk_map;
                r_coll_err <= r_chk_coll;
            end

            if (r_state == APPLY) begin
                r_act_shift <= r_chk_shift;
            end

            // flush has priority over a commit landing in the same cycle.
            if (flush) begin
                r_act_en <= '0;
            end else if (r_state == APPLY) begin
                r_act_en <= r_shadow_en;
            end
        end
    end

    // ---------------- datapath p0: rotation select ----------------
    for (genvar g = 0; g < N; g++) begin : g_sel
        assign w_rot_idx[g] = IW'(rot_idx(g, int'(r_act_shift), N));
        assign w_out_p0[g]  = r_act_en[g] ? in[w_rot_idx[g]] : '0;
        assign w_vld_p0[g]  = in_valid & r_act_en[g];
    end

    // ---------------- datapath p1: output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_p1 <= '0;
            r_vld_p1 <= '0;
        end else begin
            r_out_p1 <= w_out_p0;
            r_vld_p1 <= w_vld_p0;
        end
    end

`ifdef CROSSBAR_STATS_EN
    logic [15:0] r_commit_cnt;
    logic [15:0] r_reject_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (r_state == APPLY)  r_commit_cnt <= sat_inc16(r_commit_cnt);
            if (r_state == REJECT) r_reject_cnt <= sat_inc16(r_reject_cnt);
        end
    end

    assign cfg_commit_cnt = r_commit_cnt;
    assign cfg_reject_cnt = r_reject_cnt;
`endif

    assign cfg_ready       = w_cfg_ready;
    assign out             = r_out_p1;
    assign out_valid       = r_vld_p1;
    assign active_shift    = r_act_shift;
    assign cfg_done        = r_cfg_done;
    assign mapping_error   = r_map_err;
    assign collision_error = r_coll_err;

endmodule
